// File: rtl/watchdog_pkg.sv
// Shared types and widths for the commit-stream end-of-simulation watchdog.
package watchdog_pkg;

  localparam int ORDER_W   = 64;
  localparam int ERRCODE_W = 16;
  localparam int PC_W      = 32;

  typedef enum logic [2:0] {
    ST_RUNNING = 3'd0,
    ST_HALT    = 3'd1,
    ST_TIMEOUT = 3'd2,
    ST_ERRCODE = 3'd3,
    ST_PROTO   = 3'd4,
    ST_STALL   = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/commit_scan.sv
// Combinational scan of one cycle's commit vector: legality, first halting lane,
// and how many lanes retire once lanes above the halt are discarded.
module commit_scan
  import watchdog_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]                   commit_i,
  input  logic [NUM_CH-1:0][PC_W-1:0]         pc_rdata_i,
  input  logic [NUM_CH-1:0][PC_W-1:0]         pc_wdata_i,
  output logic                                legal_o,
  output logic                                halt_valid_o,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] halt_idx_o,
  output logic [$clog2(NUM_CH+1)-1:0]         n_commit_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic [NUM_CH-1:0] hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign hit[g] = commit_i[g] && (pc_rdata_i[g] == pc_wdata_i[g]);
  end

  // A legal vector is 2^k-1: adding one clears every set bit.
  assign legal_o = ((commit_i & (commit_i + ONE)) == '0);

  always_comb begin
    halt_valid_o = 1'b0;
    halt_idx_o   = '0;
    n_commit_o   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        halt_valid_o = 1'b1;
        halt_idx_o   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (commit_i[i] && (!halt_valid_o || (IDX_W'(i) <= halt_idx_o)))
        n_commit_o = n_commit_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/commit_watchdog.sv
// End-of-simulation controller over NUM_CH commit channels: retire ordering,
// halt/timeout/error/protocol/stall detection and a sticky termination status.
module commit_watchdog
  import watchdog_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int TIMEOUT_W    = 32,
  parameter int DRAIN_CYCLES = 5,
  parameter int IDLE_LIMIT   = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TIMEOUT_W-1:0]             timeout_limit,
  input  logic [NUM_CH-1:0]                commit,
  input  logic [NUM_CH-1:0][PC_W-1:0]      pc_rdata,
  input  logic [NUM_CH-1:0][PC_W-1:0]      pc_wdata,
  input  logic [ERRCODE_W-1:0]             errcode_in,
  output logic [NUM_CH-1:0][ORDER_W-1:0]   order_out,
  output logic [ORDER_W-1:0]               commit_count,
  output logic                             halt,
  output logic                             done,
  output logic [2:0]                       status,
  output logic [ERRCODE_W-1:0]             errcode_q
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(NUM_CH + 1);
  localparam int IDLE_W = 32;
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 1) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

  logic             legal, halt_valid;
  logic [IDX_W-1:0] halt_idx;
  logic [CNT_W-1:0] n_commit;

  commit_scan #(.NUM_CH(NUM_CH)) u_scan (
    .commit_i     (commit),
    .pc_rdata_i   (pc_rdata),
    .pc_wdata_i   (pc_wdata),
    .legal_o      (legal),
    .halt_valid_o (halt_valid),
    .halt_idx_o   (halt_idx),
    .n_commit_o   (n_commit)
  );

  state_e                 state_q, state_d;
  status_e                status_q, status_d;
  logic                   halt_q, halt_d;
  logic [ERRCODE_W-1:0]   err_q, err_d;
  logic [ORDER_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   cyc_q, cyc_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [31:0]            drain_q, drain_d;

  logic [ORDER_W:0]       cnt_sum;
  logic                   timeout_hit, stall_hit;

  assign cnt_sum     = {1'b0, cnt_q} + (ORDER_W+1)'(n_commit);
  // One extra bit so cycle_cnt + 1 cannot wrap at saturation.
  assign timeout_hit = (timeout_limit != '0) &&
                       (({1'b0, cyc_q} + (TIMEOUT_W+1)'(1)) >= {1'b0, timeout_limit});
  assign stall_hit   = (IDLE_LIMIT != 0) && (commit == '0) &&
                       (({1'b0, idle_q} + (IDLE_W+1)'(1)) >= (IDLE_W+1)'(IDLE_LIMIT));

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    halt_d   = halt_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    idle_d   = idle_q;
    drain_d  = drain_q;
    case (state_q)
      RUN: begin
        if (legal) cnt_d = cnt_sum[ORDER_W] ? '1 : cnt_sum[ORDER_W-1:0];
        cyc_d  = (&cyc_q) ? cyc_q : cyc_q + TIMEOUT_W'(1);
        idle_d = (commit != '0) ? '0 : ((&idle_q) ? idle_q : idle_q + IDLE_W'(1));
        if (errcode_in != '0) begin
          state_d  = DRAIN;
          status_d = ST_ERRCODE;
          err_d    = errcode_in;
          drain_d  = DRAIN_LOAD;
        end else if (!legal) begin
          state_d  = DRAIN;
          status_d = ST_PROTO;
          drain_d  = DRAIN_LOAD;
        end else if (halt_valid) begin
          state_d  = DONE;
          status_d = ST_HALT;
          halt_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end else if (stall_hit) begin
          state_d  = DONE;
          status_d = ST_STALL;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - 32'd1;
      end
      DONE:    ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      status_q <= ST_RUNNING;
      halt_q   <= 1'b0;
      err_q    <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      idle_q   <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      idle_q   <= idle_d;
      drain_q  <= drain_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_order
    assign order_out[g] = commit[g] ? cnt_q + ORDER_W'(g) : '0;
  end

  assign commit_count = cnt_q;
  assign halt         = halt_q;
  assign done         = (state_q == DONE);
  assign status       = status_q;
  assign errcode_q    = err_q;

  logic unused_idx;
  assign unused_idx = ^halt_idx;

endmodule

// File: tb/tb_commit_watchdog.sv
// Directed bench for commit_watchdog: expected retire orders go through a
// scoreboard queue; status/latency checks use bench-side constants.
module tb_commit_watchdog;
  import watchdog_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]      tlim = '0;
  logic [1:0]       commit = '0;
  logic [1:0][31:0] pcr = '0, pcw = '0;
  logic [15:0]      ec = '0;
  logic [1:0][63:0] order;
  logic [63:0]      ccount;
  logic             halt, done;
  logic [2:0]       status;
  logic [15:0]      errq;

  logic [31:0]      tlim2 = '0;
  logic [1:0]       commit2 = '0;
  logic [1:0][31:0] pcr2 = '0, pcw2 = '0;
  logic [15:0]      ec2 = '0;
  logic [1:0][63:0] order2;
  logic [63:0]      ccount2;
  logic             halt2, done2;
  logic [2:0]       status2;
  logic [15:0]      errq2;

  commit_watchdog #(.NUM_CH(2), .TIMEOUT_W(32), .DRAIN_CYCLES(5), .IDLE_LIMIT(1000)) dut (
    .clk(clk), .rst(rst), .timeout_limit(tlim), .commit(commit),
    .pc_rdata(pcr), .pc_wdata(pcw), .errcode_in(ec), .order_out(order),
    .commit_count(ccount), .halt(halt), .done(done), .status(status), .errcode_q(errq)
  );

  commit_watchdog #(.NUM_CH(2), .TIMEOUT_W(32), .DRAIN_CYCLES(5), .IDLE_LIMIT(8)) dut2 (
    .clk(clk), .rst(rst2), .timeout_limit(tlim2), .commit(commit2),
    .pc_rdata(pcr2), .pc_wdata(pcw2), .errcode_in(ec2), .order_out(order2),
    .commit_count(ccount2), .halt(halt2), .done(done2), .status(status2), .errcode_q(errq2)
  );

  typedef struct { logic [63:0] o0; logic [63:0] o1; } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mcnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one commit vector; the expected order_out pair is queued from the model count.
  task automatic drive(input logic [1:0] c, input logic [31:0] r0, input logic [31:0] w0,
                       input logic [31:0] r1, input logic [31:0] w1, input int inc);
    exp_t e;
    commit = c;
    pcr[0] = r0; pcw[0] = w0; pcr[1] = r1; pcw[1] = w1;
    e.o0 = c[0] ? mcnt : 64'd0;
    e.o1 = c[1] ? mcnt + 64'd1 : 64'd0;
    sb.push_back(e);
    mcnt = mcnt + 64'(inc);
  endtask

  task automatic pop_order(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_o0"}, order[0], e.o0);
      chk({tag, "_o1"}, order[1], e.o1);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st, input logic h, input logic d);
    chk({tag, "_status"}, 64'(status), 64'(st));
    chk({tag, "_halt"}, 64'(halt), 64'(h));
    chk({tag, "_done"}, 64'(done), 64'(d));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    chk_state(tag, 3'd0, 1'b0, 1'b0);
    chk({tag, "_count"}, ccount, 64'd0);
    chk({tag, "_errq"}, 64'(errq), 64'd0);
    rst = 1'b0;
    commit = '0;
    mcnt = '0;
  endtask

  initial begin
    cyc();
    // reset state of both instances
    chk_state("rst", 3'd0, 1'b0, 1'b0);
    chk("rst_count", ccount, 64'd0);
    chk("rst_errq", 64'(errq), 64'd0);
    chk("rst2_status", 64'(status2), 64'd0);
    rst = 1'b0;

    // three full-width retires with distinct PCs
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h100 + 32'(16*k), 32'h104 + 32'(16*k),
                   32'h108 + 32'(16*k), 32'h10c + 32'(16*k), 2);
      pop_order("t1");
      cyc();
    end
    chk("t1_count", ccount, 64'd6);
    chk_state("t1", 3'd0, 1'b0, 1'b0);

    // ch0 halts, ch1 discarded
    drive(2'b11, 32'h60, 32'h60, 32'h70, 32'h74, 1);
    pop_order("t2");
    cyc();
    chk_state("t2", 3'd1, 1'b1, 1'b1);
    chk("t2_count", ccount, 64'd7);
    commit = '0;

    // gap in commit vector -> PROTO with 5-cycle drain
    do_reset("t3rst");
    cyc();
    drive(2'b01, 32'h100, 32'h104, 32'h0, 32'h0, 1);
    pop_order("t3a");
    cyc();
    drive(2'b10, 32'h0, 32'h0, 32'h200, 32'h204, 0);
    pop_order("t3b");
    cyc();
    commit = '0;
    chk_state("t3", 3'd4, 1'b0, 1'b0);
    chk("t3_count", ccount, 64'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_drain_done", 64'(done), 64'd0);
    end
    cyc();
    chk_state("t3_end", 3'd4, 1'b0, 1'b1);
    chk("t3_end_count", ccount, 64'd1);

    // errcode wins over a simultaneous halt; later errcode ignored
    do_reset("t4rst");
    cyc();
    ec = 16'h0007;
    drive(2'b11, 32'h60, 32'h60, 32'h80, 32'h84, 1);
    pop_order("t4");
    cyc();
    chk_state("t4", 3'd3, 1'b0, 1'b0);
    chk("t4_errq", 64'(errq), 64'h7);
    ec = 16'h0009;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t4_drain_done", 64'(done), 64'd0);
    end
    ec = '0;
    commit = '0;
    cyc();
    chk_state("t4_end", 3'd3, 1'b0, 1'b1);
    chk("t4_end_errq", 64'(errq), 64'h7);

    // timeout after exactly 20 RUN edges with single commits
    tlim = 32'd20;
    do_reset("t5rst");
    for (int k = 0; k < 20; k++) begin
      drive(2'b01, 32'h1000 + 32'(4*k), 32'h1004 + 32'(4*k), 32'h0, 32'h0, 1);
      pop_order("t5");
      cyc();
      if (k == 18) chk_state("t5_19", 3'd0, 1'b0, 1'b0);
    end
    commit = '0;
    chk_state("t5", 3'd2, 1'b0, 1'b1);
    chk("t5_count", ccount, 64'd20);

    // live timeout lowering below the elapsed cycle count
    tlim = '0;
    do_reset("t5brst");
    for (int k = 0; k < 10; k++) cyc();
    chk_state("t5b_pre", 3'd0, 1'b0, 1'b0);
    tlim = 32'd5;
    cyc();
    chk_state("t5b", 3'd2, 1'b0, 1'b1);
    tlim = '0;

    // stall on the IDLE_LIMIT=8 instance
    rst2 = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    chk("t5c_7_status", 64'(status2), 64'd0);
    chk("t5c_7_done", 64'(done2), 64'd0);
    cyc();
    chk("t5c_status", 64'(status2), 64'd5);
    chk("t5c_done", 64'(done2), 64'd1);
    chk("t5c_count", ccount2, 64'd0);

    // async reset during DRAIN, then a clean halt
    do_reset("t6rst");
    cyc();
    drive(2'b01, 32'h300, 32'h304, 32'h0, 32'h0, 1);
    pop_order("t6a");
    cyc();
    drive(2'b10, 32'h0, 32'h0, 32'h310, 32'h314, 0);
    pop_order("t6b");
    cyc();
    commit = '0;
    cyc();
    cyc();
    chk_state("t6_drain", 3'd4, 1'b0, 1'b0);
    do_reset("t6_async");
    cyc();
    drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h0, 1);
    pop_order("t6c");
    cyc();
    commit = '0;
    chk_state("t6", 3'd1, 1'b1, 1'b1);
    chk("t6_count", ccount, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
